// File: rtl/wb_trace_serializer.sv
// WB-stage retirement trace: packs each retired instruction into a record, queues it, streams bytes.
// Optional build macro TRACE_SEQ_EN adds an 8-bit sequence byte after B0 (RECLEN 9 -> 10).
module wb_trace_serializer #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        trace_enable,
   input  logic [31:0] wb_instruction,
   input  logic        wb_shouldWriteRegister,
   input  logic [4:0]  wb_registerWriteAddress,
   input  logic [31:0] wb_registerWriteData,
   output logic [7:0]  out_data,
   output logic        out_valid,
   output logic        out_last,
   input  logic        out_ready,
   output logic        overflow,
   output logic [7:0]  drop_count,
   input  logic        clear_overflow
);

`ifdef TRACE_SEQ_EN
   localparam int RECLEN = 10;
`else
   localparam int RECLEN = 9;
`endif
   localparam int               REC_BITS   = RECLEN * 8;
   localparam logic [3:0]       LAST_IDX   = 4'(RECLEN - 1);
   localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

   typedef enum logic {IDLE, SEND} serState_t;

   serState_t           state, stateNext;
   logic [3:0]          idx, idxNext;
   logic [REC_BITS-1:0] fifoMem [DEPTH];
   logic [PTR_W-1:0]    wrPtr, rdPtr;
   logic [PTR_W:0]      count;
   logic [REC_BITS-1:0] shiftReg, newRecord;
   logic                capture, fifoFull, fifoEmpty, push, pop, drop, load;

   // Records are stored already in wire byte order so the serializer only shifts.
`ifdef TRACE_SEQ_EN
   logic [7:0] seqCount;
   assign newRecord = {wb_shouldWriteRegister, 2'b00, wb_registerWriteAddress, seqCount,
                       wb_instruction, wb_registerWriteData};
`else
   assign newRecord = {wb_shouldWriteRegister, 2'b00, wb_registerWriteAddress,
                       wb_instruction, wb_registerWriteData};
`endif

   assign capture   = trace_enable && (wb_instruction != 32'h0);
   assign fifoFull  = (count == FULL_COUNT);
   assign fifoEmpty = (count == '0);
   assign pop       = load;
   // A pop in the same cycle frees the slot, so a push at full is still accepted.
   assign push      = capture && (!fifoFull || pop);
   assign drop      = capture && fifoFull && !pop;

   assign out_valid = (state == SEND);
   assign out_last  = out_valid && (idx == LAST_IDX);
   assign out_data  = shiftReg[REC_BITS-1 -: 8];

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      stateNext = state;
      idxNext   = idx;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (!fifoEmpty) begin
               load      = 1'b1;
               idxNext   = 4'd0;
               stateNext = SEND;
            end
         end
         SEND: begin
            if (out_ready) begin
               if (idx != LAST_IDX) begin
                  idxNext = idx + 4'd1;
               end else if (!fifoEmpty) begin
                  load    = 1'b1;
                  idxNext = 4'd0;
               end else begin
                  stateNext = IDLE;
               end
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         idx        <= 4'd0;
         shiftReg   <= '0;
         wrPtr      <= '0;
         rdPtr      <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         drop_count <= 8'd0;
`ifdef TRACE_SEQ_EN
         seqCount   <= 8'd0;
`endif
      end else begin
         state <= stateNext;
         idx   <= idxNext;

         if (load) begin
            shiftReg <= fifoMem[rdPtr];
         end else if (out_valid && out_ready) begin
            shiftReg <= shiftReg << 8;
         end

         if (push) wrPtr <= wrPtr + PTR_W'(1);
         if (pop)  rdPtr <= rdPtr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_W + 1)'(1);
            2'b01:   count <= count - (PTR_W + 1)'(1);
            default: count <= count;
         endcase

         // Clear has priority: a drop in the same cycle is not counted.
         if (clear_overflow) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
         end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
         end

`ifdef TRACE_SEQ_EN
         if (push) seqCount <= seqCount + 8'd1;
`endif
      end
   end

   // NOTE: record storage is not reset; count and pointers alone decide which slots are valid.
   always_ff @(posedge clock) begin
      if (push) fifoMem[wrPtr] <= newRecord;
   end

endmodule

// File: tb/tb_wb_trace_serializer.sv
// Directed self-checking bench for wb_trace_serializer; expected bytes come from a small record model.
// Honours TRACE_SEQ_EN when the design is built with it.
module tb_wb_trace_serializer;

`ifdef TRACE_SEQ_EN
   localparam int RECLEN = 10;
`else
   localparam int RECLEN = 9;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic        trace_enable;
   logic [31:0] wb_instruction;
   logic        wb_shouldWriteRegister;
   logic [4:0]  wb_registerWriteAddress;
   logic [31:0] wb_registerWriteData;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_last;
   logic        out_ready;
   logic        overflow;
   logic [7:0]  drop_count;
   logic        clear_overflow;

   typedef struct packed {
      logic        wsr;
      logic [4:0]  addr;
      logic [31:0] instr;
      logic [31:0] data;
      logic [7:0]  seq;
   } rec_t;

   rec_t       expQ[$];
   logic [7:0] nextSeq;
   int         passCount  = 0;
   int         checkCount = 0;

   wb_trace_serializer #(.DEPTH(8), .PTR_W(3)) dut (
      .clock                  (clock),
      .reset                  (reset),
      .trace_enable           (trace_enable),
      .wb_instruction         (wb_instruction),
      .wb_shouldWriteRegister (wb_shouldWriteRegister),
      .wb_registerWriteAddress(wb_registerWriteAddress),
      .wb_registerWriteData   (wb_registerWriteData),
      .out_data               (out_data),
      .out_valid              (out_valid),
      .out_last               (out_last),
      .out_ready              (out_ready),
      .overflow               (overflow),
      .drop_count             (drop_count),
      .clear_overflow         (clear_overflow)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected)
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      else
         passCount++;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic rec_t mkRec(logic wsr, logic [4:0] addr, logic [31:0] instr, logic [31:0] data);
      rec_t r;
      r.wsr = wsr; r.addr = addr; r.instr = instr; r.data = data; r.seq = 8'd0;
      return r;
   endfunction

   function automatic logic [7:0] expByte(rec_t r, int b);
      int k;
      if (b == 0) return {r.wsr, 2'b00, r.addr};
`ifdef TRACE_SEQ_EN
      if (b == 1) return r.seq;
      k = b - 2;
`else
      k = b - 1;
`endif
      if (k < 4) return r.instr[31 - 8*k -: 8];
      return r.data[31 - 8*(k-4) -: 8];
   endfunction

   task automatic idleInputs();
      wb_instruction          = 32'h0;
      wb_shouldWriteRegister  = 1'b0;
      wb_registerWriteAddress = 5'd0;
      wb_registerWriteData    = 32'h0;
   endtask

   // Presents one retirement for one edge; inputs are left driven so calls chain back-to-back.
   task automatic captureCycle(input rec_t r, input bit accepted);
      rec_t q;
      trace_enable            = 1'b1;
      wb_instruction          = r.instr;
      wb_shouldWriteRegister  = r.wsr;
      wb_registerWriteAddress = r.addr;
      wb_registerWriteData    = r.data;
      if (accepted) begin
         q = r;
         q.seq = nextSeq;
         nextSeq = nextSeq + 8'd1;
         expQ.push_back(q);
      end
      tick();
   endtask

   task automatic doReset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      nextSeq = 8'd0;
      expQ.delete();
   endtask

   task automatic waitValid(input string tag);
      int n = 0;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
      check(tag, out_valid, 1'b1);
   endtask

   // Consumes nRec records from the model queue, driving out_ready from a 4-cycle pattern.
   task automatic drain(input int nRec, input logic [3:0] pat, input bit noGap, input string tag);
      int r = 0, b = 0, hs = 0, cyc = 0;
      bit started = 1'b0;
      while (r < nRec && cyc < 3000) begin
         out_ready = pat[cyc % 4];
         if (out_valid) begin
            started = 1'b1;
            check({tag, "_data"}, out_data, expByte(expQ[0], b));
            check({tag, "_last"}, out_last, (b == RECLEN - 1));
            if (out_ready) begin
               hs++;
               b++;
               if (b == RECLEN) begin
                  b = 0;
                  r++;
                  void'(expQ.pop_front());
               end
            end
         end else if (started && noGap) begin
            check({tag, "_gap"}, out_valid, 1'b1);
         end
         tick();
         cyc++;
      end
      check({tag, "_records"}, r, nRec);
      check({tag, "_handshakes"}, hs, nRec * RECLEN);
      out_ready = 1'b1;
   endtask

   initial begin
      trace_enable   = 1'b1;
      out_ready      = 1'b1;
      clear_overflow = 1'b0;
      idleInputs();
      doReset();

      check("rst_valid", out_valid, 1'b0);
      check("rst_last", out_last, 1'b0);
      check("rst_data", out_data, 8'h00);
      check("rst_overflow", overflow, 1'b0);
      check("rst_drops", drop_count, 8'd0);

      // Single record: 2-cycle capture-to-first-byte latency.
      captureCycle(mkRec(1'b1, 5'd8, 32'h8C080004, 32'h000000AA), 1'b1);
      idleInputs();
      check("single_lat1", out_valid, 1'b0);
      tick();
      check("single_lat2", out_valid, 1'b1);
      drain(1, 4'b1111, 1'b0, "single");
      check("single_idle", out_valid, 1'b0);

      // Bubbles and disabled capture produce nothing.
      for (int i = 0; i < 20; i++) begin
         tick();
         check("bubble_valid", out_valid, 1'b0);
      end
      trace_enable   = 1'b0;
      wb_instruction = 32'h00A00093;
      for (int i = 0; i < 5; i++) tick();
      idleInputs();
      trace_enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("disabled_valid", out_valid, 1'b0);
      end

      // Back-pressure with ready pattern 1,0,0,1.
      out_ready = 1'b0;
      captureCycle(mkRec(1'b0, 5'd5, 32'h12345678, 32'hDEADBEEF), 1'b1);
      idleInputs();
      drain(1, 4'b1001, 1'b0, "stall");

      // Overflow: 1 in shift register + 8 queued, then two drops.
      out_ready = 1'b0;
      for (int i = 1; i <= 11; i++) begin
         captureCycle(mkRec(i[0], 5'(i), 32'h10000000 + i, 32'h11111111 * i), i <= 9);
         if (i == 9)  check("ovf_before", overflow, 1'b0);
         if (i == 10) begin
            check("ovf_set", overflow, 1'b1);
            check("ovf_drop1", drop_count, 8'd1);
         end
         if (i == 11) check("ovf_drop2", drop_count, 8'd2);
      end
      idleInputs();
      drain(9, 4'b1111, 1'b1, "ovf_drain");
      check("ovf_idle", out_valid, 1'b0);
      clear_overflow = 1'b1;
      tick();
      clear_overflow = 1'b0;
      check("clr_overflow", overflow, 1'b0);
      check("clr_drops", drop_count, 8'd0);

      // Full FIFO: capture coincides with last-byte handshake of the record in flight.
      out_ready = 1'b0;
      for (int i = 1; i <= 9; i++)
         captureCycle(mkRec(1'b1, 5'd31 - 5'(i), 32'hA0000000 | i, 32'h0F0F0000 + i), 1'b1);
      idleInputs();
      for (int b = 0; b < RECLEN; b++) begin
         out_ready = 1'b1;
         check("full_valid", out_valid, 1'b1);
         check("full_data", out_data, expByte(expQ[0], b));
         if (b == RECLEN - 1) captureCycle(mkRec(1'b0, 5'd3, 32'hCAFEF00D, 32'h55AA55AA), 1'b1);
         else tick();
         idleInputs();
      end
      void'(expQ.pop_front());
      check("full_drops", drop_count, 8'd0);
      check("full_overflow", overflow, 1'b0);
      drain(9, 4'b1111, 1'b1, "full_drain");

      // Reset after 4 bytes, with more records queued behind.
      out_ready = 1'b0;
      captureCycle(mkRec(1'b1, 5'd1, 32'h11223344, 32'h55667788), 1'b1);
      captureCycle(mkRec(1'b1, 5'd2, 32'h99AABBCC, 32'hDDEEFF00), 1'b1);
      captureCycle(mkRec(1'b0, 5'd4, 32'h0BADC0DE, 32'h00000001), 1'b1);
      idleInputs();
      waitValid("mid_wait");
      for (int b = 0; b < 4; b++) begin
         out_ready = 1'b1;
         check("mid_data", out_data, expByte(expQ[0], b));
         tick();
      end
      reset = 1'b1;
      tick();
      check("mid_rst_valid", out_valid, 1'b0);
      check("mid_rst_last", out_last, 1'b0);
      check("mid_rst_data", out_data, 8'h00);
      reset = 1'b0;
      nextSeq = 8'd0;
      expQ.delete();
      for (int i = 0; i < 3; i++) begin
         tick();
         check("mid_rst_empty", out_valid, 1'b0);
      end
      captureCycle(mkRec(1'b1, 5'd17, 32'hFEEDBEEF, 32'h13579BDF), 1'b1);
      idleInputs();
      drain(1, 4'b1111, 1'b0, "post_rst");

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
